invsqrt_nr_pipe: RTL and testbench
==================================

# invsqrt_nr_pipe

Parametrised, fully pipelined IEEE-754 single-precision fast inverse square root (1/√x). It seeds with a magic-constant bit trick and refines with a configurable number of Newton–Raphson stages. It succeeds the fixed-iteration inverse-square-root core and adds input-valid qualification, a sideband tag, explicit special-value handling with exception flags, and clean single-pulse output under clock-enable stalls. It sits in the float datapath between an upstream sample source and a downstream consumer, with one result per input per cycle.

## Interface
- NR_ITERS, 1: Newton–Raphson iterations, legal range 1..3.
- MAGIC, 32'h5F3759DF: seed constant.
- TAG_W, 4: sideband tag width, ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes the whole pipeline.
- InValid  in  1  DataIn/TagIn carry a sample this cycle (sampled only when ce=1).
- DataIn  in  32  float32 operand x.
- TagIn  in  TAG_W  sideband tag, travels with the sample.
- DataOut  out  32  float32 result 1/√x.
- TagOut  out  TAG_W  tag of the sample on DataOut.
- ExcFlag  out  2  [0]=invalid operation, [1]=divide-by-zero; qualified by DataValid.
- DataValid  out  1  one-cycle pulse per completed sample.

## Operation
- Stage S0 (input register), loaded when ce=1:
  - Denormal inputs (exp=0, mant≠0) are flushed to signed zero.
  - Input is classified as zero, negative non-zero, +inf, NaN or normal positive.
  - Seed: y0 = MAGIC − (x >> 1), as 32-bit integer subtraction.
  - Half-input: xh = x with exponent decremented by 1, computed only for normal positive x.
  - Valid, tag and class are captured.
- Each NR iteration takes 4 registered stages:
  - a = y·y
  - b = xh·a
  - c = 1.5 − b
  - y = y·c
- Multiplies: 24×24 mantissa product, single-bit normalise, truncate to 23 fraction bits, exponents added and rebiased.
- Subtract stage: c is computed in ≥26-bit fixed point, then normalised and truncated. b always lies in [0.4, 0.6], so c cannot underflow or change sign.
- No overflow or underflow is possible for normal positive x: the result range is [5.4e-20, 9.3e18].
- Class, valid and tag shift alongside the data through every stage.
- Output stage muxes in special results:
  - ±0 → ±inf (7F800000 / FF800000), ExcFlag=2'b10.
  - negative non-zero → 7FC00000, ExcFlag=2'b01.
  - +inf → 00000000, ExcFlag=2'b00.
  - NaN (any sign or payload) → 7FC00000, ExcFlag=2'b01.
  - normal positive → refined y, sign 0, ExcFlag=2'b00.
- Accuracy versus the exact value, normal inputs:
  - NR_ITERS=1: relative error ≤ 0.18%.
  - NR_ITERS=2: relative error ≤ 5e-6.
  - NR_ITERS=3: error ≤ 4 ULP.
- A cycle with InValid=0 and ce=1 injects a bubble. Bubbles produce no DataValid.

## Timing
- Latency L = 4·NR_ITERS + 2 ce-active cycles, from the edge that samples DataIn to the edge that raises DataValid. L = 6, 10, 14 for NR_ITERS = 1, 2, 3.
- Throughput: one sample per ce-active cycle. There is no other backpressure.
- ce=0:
  - All pipeline data, valid, tag and class registers hold.
  - DataOut, TagOut and ExcFlag hold.
  - DataValid is loaded with 0.
- ce=1: DataValid ← valid bit of the last stage. Each sample therefore pulses DataValid exactly once, whatever the stall pattern.
- Samples emerge in input order, with no loss and no duplication.
- Reset values: DataOut=0, TagOut=0, ExcFlag=0, DataValid=0, all internal valid bits 0.
- Asserting rst mid-operation discards all in-flight samples immediately.
- After rst deassertion, the first sample accepted emerges after exactly L ce-active cycles.
- rst and ce=0 together: reset dominates.

## Test plan
- Single normal sample, NR_ITERS=1: DataIn=40800000, TagIn=4'h5, InValid=1 for one cycle → DataValid single pulse exactly 6 cycles later, DataOut in [3EFF8000, 3F000000], TagOut=5, ExcFlag=0.
- Back-to-back specials, one per cycle → outputs on 6 consecutive cycles, in order:
  - 00000000 → 7F800000 / 2'b10
  - 80000000 → FF800000 / 2'b10
  - BF800000 → 7FC00000 / 2'b01
  - 7F800000 → 00000000 / 2'b00
  - 7FC00001 → 7FC00000 / 2'b01
  - 00000001 → 7F800000 / 2'b10
- Stall during streaming: 1000 random positive floats, InValid=1, tag = index mod 16, ce=0 for cycles 400–410 → exactly 1000 DataValid pulses, in order, tags matching, no pulse while ce=0, each result within the NR_ITERS=1 bound of a double-precision model.
- Bubbles: InValid pattern 1,0,0,1 with ce=1 → exactly 2 DataValid pulses, 3 cycles apart.
- Reset mid-flight: 3 samples launched, rst asserted for 1 cycle 2 cycles later → DataValid never rises for them and all outputs read 0. A new sample after release appears at exactly L.
- Accuracy sweep: NR_ITERS=2 and NR_ITERS=3 builds, 10000 random normal positives, exponents spanning 01..FE → max relative error ≤ 5e-6 and ≤ 4 ULP respectively; L measured as 10 and 14.

Source files
------------

// File: rtl/invsqrt_nr_pipe_if.sv
// Sample/result bus for the pipelined inverse square root.
//   InValid/DataIn/TagIn     : upstream sample (driven by master)
//   DataOut/TagOut/ExcFlag   : result, qualified by DataValid (driven by slave)
//   DataValid                : one-cycle pulse per completed sample
interface invsqrt_nr_pipe_if #(
  parameter int unsigned TAG_W = 4
);
  logic             InValid;
  logic [31:0]      DataIn;
  logic [TAG_W-1:0] TagIn;
  logic [31:0]      DataOut;
  logic [TAG_W-1:0] TagOut;
  logic [1:0]       ExcFlag;
  logic             DataValid;

  modport master (
    output InValid, DataIn, TagIn,
    input  DataOut, TagOut, ExcFlag, DataValid
  );

  modport slave (
    input  InValid, DataIn, TagIn,
    output DataOut, TagOut, ExcFlag, DataValid
  );
endinterface

// File: rtl/invsqrt_nr_pipe.sv
// Fully pipelined float32 inverse square root: magic-constant seed followed
// by NR_ITERS Newton-Raphson refinements, four register stages each.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears every stage
//   ce   : clock enable; 0 freezes the pipeline, DataValid drops to 0
//   bus  : slave side of invsqrt_nr_pipe_if (sample in, result out)
// Latency is 4*NR_ITERS + 2 ce-active cycles; ExcFlag[0]=invalid,
// ExcFlag[1]=divide-by-zero.
module invsqrt_nr_pipe #(
  parameter int unsigned NR_ITERS = 1,
  parameter logic [31:0] MAGIC    = 32'h5F3759DF,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  invsqrt_nr_pipe_if.slave bus
);
  localparam int unsigned NS = 4 * NR_ITERS;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_NEG,
    CLS_PINF,
    CLS_NAN
  } cls_t;

  // Positive-only multiply with an always-present hidden bit. Exponents are
  // handled modulo 256: y*y can leave the normal range for x near the top of
  // the float range, but every later product brings it back, so wrapped
  // intermediate exponents still give the correct final value.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] f;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127 + {7'b0, p[47]};
    f = p[47] ? p[46:24] : p[45:23];
    return {1'b0, e, f};
  endfunction

  // c = 1.5 - b in 26-bit-fraction fixed point; b sits in [0.4, 0.6] so c is
  // in [0.9, 1.1] and needs at most a one-position normalise.
  function automatic logic [31:0] fsub15(input logic [31:0] b);
    logic [7:0]  sh;
    logic [27:0] bfx;
    logic [27:0] cfx;
    sh  = 8'd127 - b[30:23];
    bfx = {2'b01, b[22:0], 3'b000} >> sh;
    cfx = 28'h600_0000 - bfx;
    if (cfx[26]) return {1'b0, 8'd127, cfx[25:3]};
    else         return {1'b0, 8'd126, cfx[24:2]};
  endfunction

  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_sgn;
  cls_t        w_cls;
  logic [31:0] w_seed;
  logic [31:0] w_xh;

  assign w_exp  = bus.DataIn[30:23];
  assign w_man  = bus.DataIn[22:0];
  assign w_sgn  = bus.DataIn[31];
  assign w_seed = MAGIC - {1'b0, bus.DataIn[31:1]};
  assign w_xh   = (w_cls == CLS_NORM) ? {1'b0, w_exp - 8'd1, w_man} : '0;

  // Denormals share exp=0 with zero, so they are flushed to signed zero here.
  always_comb begin
    w_cls = CLS_NORM;
    if (w_exp == 8'h00)                       w_cls = CLS_ZERO;
    else if (w_exp == 8'hFF && w_man != '0)   w_cls = CLS_NAN;
    else if (w_sgn)                           w_cls = CLS_NEG;
    else if (w_exp == 8'hFF)                  w_cls = CLS_PINF;
  end

  // Index 0 is the input stage; stage s applies NR step (s-1)%4.
  logic [31:0]      r_y   [NS+1];
  logic [31:0]      r_xh  [NS+1];
  logic [31:0]      r_t   [NS+1];
  logic             r_vld [NS+1];
  logic             r_sgn [NS+1];
  cls_t             r_cls [NS+1];
  logic [TAG_W-1:0] r_tag [NS+1];

  logic [31:0]      w_mx_data;
  logic [1:0]       w_mx_exc;
  logic [31:0]      r_mx_data;
  logic [1:0]       r_mx_exc;
  logic [TAG_W-1:0] r_mx_tag;
  logic             r_mx_vld;

  logic [31:0]      r_dout;
  logic [TAG_W-1:0] r_tout;
  logic [1:0]       r_exc;
  logic             r_dv;

  always_comb begin
    w_mx_data = {1'b0, r_y[NS][30:0]};
    w_mx_exc  = 2'b00;
    case (r_cls[NS])
      CLS_ZERO: begin
        w_mx_data = {r_sgn[NS], 8'hFF, 23'd0};
        w_mx_exc  = 2'b10;
      end
      CLS_NEG, CLS_NAN: begin
        w_mx_data = 32'h7FC0_0000;
        w_mx_exc  = 2'b01;
      end
      CLS_PINF: w_mx_data = '0;
      default: ;
    endcase
  end

  // Special-value muxing gets its own register ahead of the output register
  // so the output register only has to implement the DataValid stall rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s <= NS; s++) begin
        r_y[s]   <= '0;
        r_xh[s]  <= '0;
        r_t[s]   <= '0;
        r_vld[s] <= 1'b0;
        r_sgn[s] <= 1'b0;
        r_cls[s] <= CLS_NORM;
        r_tag[s] <= '0;
      end
      r_mx_data <= '0;
      r_mx_exc  <= '0;
      r_mx_tag  <= '0;
      r_mx_vld  <= 1'b0;
      r_dout    <= '0;
      r_tout    <= '0;
      r_exc     <= '0;
      r_dv      <= 1'b0;
    end else begin
      if (ce) begin
        r_y[0]   <= w_seed;
        r_xh[0]  <= w_xh;
        r_t[0]   <= '0;
        r_vld[0] <= bus.InValid;
        r_sgn[0] <= w_sgn;
        r_cls[0] <= w_cls;
        r_tag[0] <= bus.TagIn;
        for (int unsigned s = 1; s <= NS; s++) begin
          r_y[s]   <= r_y[s-1];
          r_xh[s]  <= r_xh[s-1];
          r_t[s]   <= r_t[s-1];
          r_vld[s] <= r_vld[s-1];
          r_sgn[s] <= r_sgn[s-1];
          r_cls[s] <= r_cls[s-1];
          r_tag[s] <= r_tag[s-1];
          case ((s - 1) % 4)
            0:       r_t[s] <= fmul(r_y[s-1], r_y[s-1]);
            1:       r_t[s] <= fmul(r_xh[s-1], r_t[s-1]);
            2:       r_t[s] <= fsub15(r_t[s-1]);
            default: r_y[s] <= fmul(r_y[s-1], r_t[s-1]);
          endcase
        end
        r_mx_data <= w_mx_data;
        r_mx_exc  <= w_mx_exc;
        r_mx_tag  <= r_tag[NS];
        r_mx_vld  <= r_vld[NS];
        r_dout    <= r_mx_data;
        r_tout    <= r_mx_tag;
        r_exc     <= r_mx_exc;
      end
      r_dv <= ce ? r_mx_vld : 1'b0;
    end
  end

  assign bus.DataOut   = r_dout;
  assign bus.TagOut    = r_tout;
  assign bus.ExcFlag   = r_exc;
  assign bus.DataValid = r_dv;
endmodule

// File: tb/tb_invsqrt_nr_pipe.sv
// Self-checking bench: three instances (NR_ITERS = 1, 2, 3) share one
// stimulus stream; results are checked against a scoreboard of expected
// values and a double-precision 1/sqrt(x) reference.
module tb_invsqrt_nr_pipe;
  localparam int TW = 4;

  typedef struct {
    logic [31:0]   x;
    logic [TW-1:0] tag;
    logic          special;
    logic [31:0]   exp_data;
    logic [1:0]    exp_exc;
    int            stamp;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          in_valid;
  logic [31:0]   data_in;
  logic [TW-1:0] tag_in;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_cnt = 0;
  int lat [3];
  int rd  [3];
  sb_t q[$];

  always #5 clk = ~clk;

  invsqrt_nr_pipe_if #(.TAG_W(TW)) bus1 ();
  invsqrt_nr_pipe_if #(.TAG_W(TW)) bus2 ();
  invsqrt_nr_pipe_if #(.TAG_W(TW)) bus3 ();

  assign bus1.InValid = in_valid;
  assign bus1.DataIn  = data_in;
  assign bus1.TagIn   = tag_in;
  assign bus2.InValid = in_valid;
  assign bus2.DataIn  = data_in;
  assign bus2.TagIn   = tag_in;
  assign bus3.InValid = in_valid;
  assign bus3.DataIn  = data_in;
  assign bus3.TagIn   = tag_in;

  invsqrt_nr_pipe #(.NR_ITERS(1), .MAGIC(32'h5F3759DF), .TAG_W(TW)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus1));
  invsqrt_nr_pipe #(.NR_ITERS(2), .MAGIC(32'h5F3759DF), .TAG_W(TW)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus2));
  invsqrt_nr_pipe #(.NR_ITERS(3), .MAGIC(32'h5F3759DF), .TAG_W(TW)) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus3));

  logic          dv   [3];
  logic [31:0]   dout [3];
  logic [TW-1:0] tout [3];
  logic [1:0]    exc  [3];

  assign dv[0] = bus1.DataValid;  assign dout[0] = bus1.DataOut;
  assign tout[0] = bus1.TagOut;   assign exc[0] = bus1.ExcFlag;
  assign dv[1] = bus2.DataValid;  assign dout[1] = bus2.DataOut;
  assign tout[1] = bus2.TagOut;   assign exc[1] = bus2.ExcFlag;
  assign dv[2] = bus3.DataValid;  assign dout[2] = bus3.DataOut;
  assign tout[2] = bus3.TagOut;   assign exc[2] = bus3.ExcFlag;

  function automatic real fval(input logic [31:0] f);
    return (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(f[30:23]) - 127.0));
  endfunction

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ce && !rst) ce_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; data_in = '0; tag_in = '0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (dv[d] !== 1'b0) begin n_bad++; $display("FAIL reset_dv dut%0d got=%b want=0", d, dv[d]); end
      n_cmp++; if (dout[d] !== 32'h0) begin n_bad++; $display("FAIL reset_data dut%0d got=%h want=0", d, dout[d]); end
      n_cmp++; if (tout[d] !== '0) begin n_bad++; $display("FAIL reset_tag dut%0d got=%h want=0", d, tout[d]); end
      n_cmp++; if (exc[d] !== 2'b00) begin n_bad++; $display("FAIL reset_exc dut%0d got=%b want=00", d, exc[d]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int when [3];
    int pulses [3];
    logic [31:0] got [3];
    logic [TW-1:0] gtag [3];
    logic [1:0] gexc [3];
    for (int d = 0; d < 3; d++) begin when[d] = -1; pulses[d] = 0; got[d] = '0; gtag[d] = '0; gexc[d] = '0; end
    in_valid = 1'b1; data_in = 32'h4080_0000; tag_in = 4'h5;
    tick();
    in_valid = 1'b0; data_in = '0; tag_in = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int d = 0; d < 3; d++) if (dv[d]) begin
        pulses[d]++; when[d] = c; got[d] = dout[d]; gtag[d] = tout[d]; gexc[d] = exc[d];
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (pulses[d] !== 1) begin n_bad++; $display("FAIL single_pulses dut%0d got=%0d want=1", d, pulses[d]); end
      n_cmp++; if (when[d] !== lat[d]) begin n_bad++; $display("FAIL single_latency dut%0d got=%0d want=%0d", d, when[d], lat[d]); end
      n_cmp++; if (got[d] < 32'h3EFF_8000 || got[d] > 32'h3F00_0000)
        begin n_bad++; $display("FAIL single_data dut%0d got=%h want 3EFF8000..3F000000", d, got[d]); end
      n_cmp++; if (gtag[d] !== 4'h5) begin n_bad++; $display("FAIL single_tag dut%0d got=%h want=5", d, gtag[d]); end
      n_cmp++; if (gexc[d] !== 2'b00) begin n_bad++; $display("FAIL single_exc dut%0d got=%b want=00", d, gexc[d]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] sx [8];
    logic [31:0] sy [8];
    logic [1:0]  se [8];
    int first [3];
    int last [3];
    sb_t it;
    sx[0] = 32'h0000_0000; sy[0] = 32'h7F80_0000; se[0] = 2'b10;
    sx[1] = 32'h8000_0000; sy[1] = 32'hFF80_0000; se[1] = 2'b10;
    sx[2] = 32'hBF80_0000; sy[2] = 32'h7FC0_0000; se[2] = 2'b01;
    sx[3] = 32'h7F80_0000; sy[3] = 32'h0000_0000; se[3] = 2'b00;
    sx[4] = 32'h7FC0_0001; sy[4] = 32'h7FC0_0000; se[4] = 2'b01;
    sx[5] = 32'h0000_0001; sy[5] = 32'h7F80_0000; se[5] = 2'b10;
    sx[6] = 32'hFF80_0000; sy[6] = 32'h7FC0_0000; se[6] = 2'b01;
    sx[7] = 32'h8000_0001; sy[7] = 32'hFF80_0000; se[7] = 2'b10;
    q.delete();
    for (int d = 0; d < 3; d++) begin rd[d] = 0; first[d] = -1; last[d] = -1; end
    for (int c = 0; c < 40; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; data_in = sx[c]; tag_in = TW'(c + 8);
        q.push_back('{x: sx[c], tag: TW'(c + 8), special: 1'b1, exp_data: sy[c], exp_exc: se[c], stamp: ce_cnt + 1});
      end else begin
        in_valid = 1'b0; data_in = '0; tag_in = '0;
      end
      tick();
      for (int d = 0; d < 3; d++) if (dv[d]) begin
        if (rd[d] >= q.size()) begin
          n_cmp++; n_bad++; $display("FAIL spec_extra dut%0d got=%h want no pulse", d, dout[d]);
        end else begin
          it = q[rd[d]]; rd[d]++;
          n_cmp++; if (dout[d] !== it.exp_data) begin n_bad++; $display("FAIL spec_data dut%0d x=%h got=%h want=%h", d, it.x, dout[d], it.exp_data); end
          n_cmp++; if (exc[d] !== it.exp_exc) begin n_bad++; $display("FAIL spec_exc dut%0d x=%h got=%b want=%b", d, it.x, exc[d], it.exp_exc); end
          n_cmp++; if (tout[d] !== it.tag) begin n_bad++; $display("FAIL spec_tag dut%0d got=%h want=%h", d, tout[d], it.tag); end
          n_cmp++; if (ce_cnt - it.stamp !== lat[d]) begin n_bad++; $display("FAIL spec_latency dut%0d got=%0d want=%0d", d, ce_cnt - it.stamp, lat[d]); end
          if (first[d] < 0) first[d] = c;
          last[d] = c;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (rd[d] !== 8) begin n_bad++; $display("FAIL spec_count dut%0d got=%0d want=8", d, rd[d]); end
      n_cmp++; if (last[d] - first[d] !== 7) begin n_bad++; $display("FAIL spec_consecutive dut%0d got span=%0d want=7", d, last[d] - first[d]); end
    end
  endtask

  task automatic test_bubbles();
    int pulses [3];
    int t0 [3];
    int t1 [3];
    for (int d = 0; d < 3; d++) begin pulses[d] = 0; t0[d] = -1; t1[d] = -1; end
    for (int c = 0; c < 30; c++) begin
      in_valid = (c == 0 || c == 3);
      data_in = 32'h3F80_0000; tag_in = TW'(c);
      tick();
      for (int d = 0; d < 3; d++) if (dv[d]) begin
        pulses[d]++;
        if (t0[d] < 0) t0[d] = c; else t1[d] = c;
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (pulses[d] !== 2) begin n_bad++; $display("FAIL bubble_count dut%0d got=%0d want=2", d, pulses[d]); end
      n_cmp++; if (t1[d] - t0[d] !== 3) begin n_bad++; $display("FAIL bubble_gap dut%0d got=%0d want=3", d, t1[d] - t0[d]); end
    end
  endtask

  task automatic test_reset_midflight();
    int when [3];
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; data_in = 32'h4100_0000 + 32'(c); tag_in = TW'(c + 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    // reset together with ce=0: reset must still win
    rst = 1'b1; ce = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (dout[d] !== 32'h0 || tout[d] !== '0 || exc[d] !== 2'b00 || dv[d] !== 1'b0) begin
        n_bad++; $display("FAIL midrst_outputs dut%0d got data=%h tag=%h exc=%b dv=%b want all 0", d, dout[d], tout[d], exc[d], dv[d]);
      end
    end
    tick();
    rst = 1'b0; ce = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++; if (dv[d] !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost dut%0d cycle=%0d got dv=%b want=0", d, c, dv[d]); end
      end
    end
    for (int d = 0; d < 3; d++) when[d] = -1;
    in_valid = 1'b1; data_in = 32'h3F80_0000; tag_in = 4'hA;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int d = 0; d < 3; d++) if (dv[d] && when[d] < 0) when[d] = c;
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (when[d] !== lat[d]) begin n_bad++; $display("FAIL midrst_latency dut%0d got=%0d want=%0d", d, when[d], lat[d]); end
    end
  endtask

  task automatic test_stream(input int n, input int st_lo, input int st_hi);
    int issued = 0;
    int cyc = 0;
    int budget;
    logic [31:0] x;
    sb_t it;
    real exact, got, err, ulp;
    bit ok;
    q.delete();
    for (int d = 0; d < 3; d++) rd[d] = 0;
    budget = n + 200 + ((st_hi >= st_lo) ? (st_hi - st_lo + 1) : 0);
    while (1) begin
      ce = !(cyc >= st_lo && cyc <= st_hi);
      if (issued < n) begin
        case (issued)
          0:       x = {1'b0, 8'h01, 23'h000000};
          1:       x = {1'b0, 8'hFE, 23'h7FFFFF};
          2:       x = {1'b0, 8'h7F, 23'h000000};
          default: x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
        in_valid = 1'b1; data_in = x; tag_in = issued[TW-1:0];
        if (ce) begin
          q.push_back('{x: x, tag: issued[TW-1:0], special: 1'b0, exp_data: '0, exp_exc: 2'b00, stamp: ce_cnt + 1});
          issued++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (!ce) begin
          n_cmp++; if (dv[d] !== 1'b0) begin n_bad++; $display("FAIL stall_pulse dut%0d cycle=%0d got dv=%b want=0", d, cyc, dv[d]); end
        end
        if (dv[d]) begin
          if (rd[d] >= q.size()) begin
            n_cmp++; n_bad++; $display("FAIL stream_extra dut%0d got=%h want no pulse", d, dout[d]);
          end else begin
            it = q[rd[d]]; rd[d]++;
            exact = 1.0 / $sqrt(fval(it.x));
            got = fval(dout[d]);
            err = rabs(got - exact);
            ulp = 2.0 ** (real'(dout[d][30:23]) - 150.0);
            if (d == 0)      ok = (err / exact) <= 0.0018;
            else if (d == 1) ok = (err / exact) <= 5.0e-6;
            else             ok = err <= 4.0 * ulp;
            n_cmp++; if (!ok || dout[d][31] !== 1'b0) begin
              n_bad++; $display("FAIL stream_accuracy dut%0d x=%h got=%h ref=%e rel=%e", d, it.x, dout[d], exact, err / exact);
            end
            n_cmp++; if (tout[d] !== it.tag) begin n_bad++; $display("FAIL stream_tag dut%0d idx=%0d got=%h want=%h", d, rd[d] - 1, tout[d], it.tag); end
            n_cmp++; if (exc[d] !== 2'b00) begin n_bad++; $display("FAIL stream_exc dut%0d x=%h got=%b want=00", d, it.x, exc[d]); end
            n_cmp++; if (ce_cnt - it.stamp !== lat[d]) begin n_bad++; $display("FAIL stream_latency dut%0d got=%0d want=%0d", d, ce_cnt - it.stamp, lat[d]); end
          end
        end
      end
      if (issued == n && rd[0] == n && rd[1] == n && rd[2] == n) break;
      if (cyc > budget) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_timeout got=%0d/%0d/%0d results want=%0d", rd[0], rd[1], rd[2], n);
        break;
      end
    end
    in_valid = 1'b0; ce = 1'b1;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (rd[d] !== n) begin n_bad++; $display("FAIL stream_count dut%0d got=%0d want=%0d", d, rd[d], n); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

  initial begin
    lat[0] = 6; lat[1] = 10; lat[2] = 14;
    test_reset();
    test_single();
    test_specials();
    test_bubbles();
    test_reset_midflight();
    test_stream(1000, 400, 410);
    test_stream(10000, -1, -2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
